ram_burst_ctrl: RTL and testbench

- Burst access engine sitting directly upstream of the single-port RAM (1024 x 8, synchronous write, one-cycle synchronous read).
- Accepts one command at a time (start address, length, direction).
- Write bursts: moves a valid/ready byte stream into consecutive RAM locations.
- Read bursts: streams consecutive RAM bytes out on a valid/ready interface, absorbing the RAM read latency so back-pressure never loses data.

---
 rtl/ram_burst_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst engine in front of a single-port synchronous RAM: streams write bytes into
// consecutive locations, or reads consecutive locations out through a 2-entry skid FIFO.
module ram_burst_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_done_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_inflight;
    logic              r_done;

    logic [DATA_W-1:0] r_fifo [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_fcnt;

    logic              w_accept;
    logic              w_wbeat;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_credit;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_wbeat  = (r_state == S_WRITE) && wdata_valid;
    assign w_pop    = (r_fcnt != 2'd0) && rdata_ready;
    assign w_push   = r_inflight;
    // Occupancy the FIFO will have once the in-flight byte lands; keeps a slot for every read issued.
    assign w_credit = 3'(r_fcnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue  = (r_state == S_READ) && (w_credit < 3'd2);

    assign cmd_ready   = (r_state == S_IDLE);
    assign wdata_ready = (r_state == S_WRITE);
    assign ram_wr      = w_wbeat;
    assign ram_din     = (r_state == S_WRITE) ? wdata : DATA_W'(0);
    assign ram_addr    = ((r_state == S_WRITE) || w_issue) ? r_addr : r_last_addr;
    assign rdata_valid = (r_fcnt != 2'd0);
    assign rdata       = r_fifo[r_rd_ptr];
    assign done        = r_done;

    // Next-state and completion pulse
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_wbeat && (r_cnt == '0)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_READ: begin
                if (w_issue && (r_cnt == '0)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_fcnt == 2'd1) && !r_inflight) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_last_addr <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_last_addr <= ram_addr;
            r_inflight  <= w_issue;
            if (w_accept) begin
                r_addr <= cmd_addr;
                r_cnt  <= cmd_len;
            end else if (w_wbeat || w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt - ADDR_W'(1);
            end
        end
    end

    // Skid FIFO capturing RAM read data one cycle after each issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_fcnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_fcnt <= r_fcnt + 2'd1;
            end else if (!w_push && w_pop) begin
                r_fcnt <= r_fcnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 1024x8 synchronous RAM attached.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [9:0] cmd_len = '0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] wdata = 8'hA5;
    logic       rdata_valid;
    logic       rdata_ready = 1'b0;
    logic [7:0] rdata;
    logic       done;
    logic       ram_wr;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [1024];

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic [9:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] rd_q [$];

    ram_burst_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Inputs only change #1 after posedge, so negedge values are what the next edge consumes.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr) begin
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_din);
            end
            if (rdata_valid && rdata_ready) rd_q.push_back(rdata);
            if (done) done_cnt++;
        end
    end

    task automatic issue_cmd(input logic wr, input logic [9:0] a, input logic [9:0] l);
        bit seen = 1'b0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_total++;
        if (!seen) $display("FAIL cmd_accept: cmd_ready stayed 0, required 1");
        else n_pass++;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_write(input logic [7:0] d [$], input int gap);
        foreach (d[i]) begin
            wdata_valid = 1'b1; wdata = d[i];
            @(posedge clk); #1;
            wdata_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (wdata_ready !== 1'b0) $display("FAIL rst_wdata_ready: got %b want 0", wdata_ready); else n_pass++;
        n_total++; if (rdata_valid !== 1'b0) $display("FAIL rst_rdata_valid: got %b want 0", rdata_valid); else n_pass++;
        n_total++; if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rdata); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_total++; if (ram_wr !== 1'b0) $display("FAIL rst_ram_wr: got %b want 0", ram_wr); else n_pass++;
        n_total++; if (ram_addr !== 10'h000) $display("FAIL rst_ram_addr: got %h want 000", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'h00) $display("FAIL rst_ram_din: got %h want 00", ram_din); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_burst();
        bit ok;
        int d0 = done_cnt;
        logic [9:0] ea [2] = '{10'h0FF, 10'h100};
        logic [7:0] ed [2] = '{8'hEC, 8'hEB};
        wr_addr_q.delete(); wr_data_q.delete();
        issue_cmd(1'b1, 10'h0FF, 10'd1);
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1; wdata = ed[i];
            @(negedge clk);
            n_total++; if (wdata_ready !== 1'b1) $display("FAIL wr_wdata_ready: got %b want 1", wdata_ready); else n_pass++;
            n_total++; if (cmd_ready !== 1'b0) $display("FAIL wr_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
            n_total++; if (rdata_valid !== 1'b0) $display("FAIL wr_rdata_valid: got %b want 0", rdata_valid); else n_pass++;
            n_total++; if (ram_addr !== ea[i]) $display("FAIL wr_ram_addr: got %h want %h", ram_addr, ea[i]); else n_pass++;
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        wait_done(10, ok);
        n_total++; if (!ok) $display("FAIL wr_done: no done pulse within budget"); else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_total++; if (wr_addr_q.size() != 2) $display("FAIL wr_count: got %0d writes want 2", wr_addr_q.size()); else n_pass++;
        for (int i = 0; i < wr_addr_q.size() && i < 2; i++) begin
            n_total++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i])
                $display("FAIL wr_beat%0d: got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], ed[i], ea[i]); else n_pass++;
        end
        n_total++; if (done_cnt - d0 != 1) $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        // Read the pair back
        rd_q.delete(); rdata_ready = 1'b1;
        issue_cmd(1'b0, 10'h0FF, 10'd1);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL rb_done: no done pulse within budget"); else n_pass++;
        n_total++; if (rd_q.size() != 2) $display("FAIL rb_count: got %0d want 2", rd_q.size()); else n_pass++;
        for (int i = 0; i < rd_q.size() && i < 2; i++) begin
            n_total++; if (rd_q[i] !== ed[i]) $display("FAIL rb_byte%0d: got %h want %h", i, rd_q[i], ed[i]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] d [$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [9:0] ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        wr_addr_q.delete(); wr_data_q.delete();
        issue_cmd(1'b1, 10'h3FE, 10'd3);
        drive_write(d, 0);
        wait_done(10, ok);
        n_total++; if (!ok) $display("FAIL wrap_wr_done: no done pulse"); else n_pass++;
        n_total++; if (wr_addr_q.size() != 4) $display("FAIL wrap_wr_count: got %0d want 4", wr_addr_q.size()); else n_pass++;
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            n_total++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== d[i])
                $display("FAIL wrap_wr%0d: got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], d[i], ea[i]); else n_pass++;
        end
        rd_q.delete(); rdata_ready = 1'b1;
        issue_cmd(1'b0, 10'h3FE, 10'd3);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL wrap_rd_done: no done pulse"); else n_pass++;
        n_total++; if (rd_q.size() != 4) $display("FAIL wrap_rd_count: got %0d want 4", rd_q.size()); else n_pass++;
        for (int i = 0; i < rd_q.size() && i < 4; i++) begin
            n_total++; if (rd_q[i] !== d[i]) $display("FAIL wrap_rd%0d: got %h want %h", i, rd_q[i], d[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok = 1'b0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        int n_at_done = -1;
        int d0;
        logic [7:0] d [$];
        for (int i = 0; i < 8; i++) d.push_back(8'(8'hA0 + i));
        issue_cmd(1'b1, 10'h200, 10'd7);
        drive_write(d, 0);
        wait_done(10, ok);
        rd_q.delete(); d0 = done_cnt; rdata_ready = 1'b0; ok = 1'b0;
        issue_cmd(1'b0, 10'h200, 10'd7);
        for (int k = 0; k < 80 && !ok; k++) begin
            rdata_ready = (k >= 6 && k < 11) ? 1'b0 : 1'(k % 2);
            @(negedge clk);
            if (prev_stall) begin
                n_total++; if (rdata_valid !== 1'b1 || rdata !== prev_data)
                    $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h", rdata_valid, rdata, prev_data); else n_pass++;
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev_data  = rdata;
            if (done) begin ok = 1'b1; n_at_done = rd_q.size(); end
            @(posedge clk); #1;
        end
        rdata_ready = 1'b0;
        n_total++; if (!ok) $display("FAIL bp_done: no done pulse within budget"); else n_pass++;
        n_total++; if (n_at_done != 8) $display("FAIL bp_done_timing: bytes at done %0d want 8", n_at_done); else n_pass++;
        n_total++; if (done_cnt - d0 != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_total++; if (rd_q.size() != 8) $display("FAIL bp_count: got %0d want 8", rd_q.size()); else n_pass++;
        for (int i = 0; i < rd_q.size() && i < 8; i++) begin
            n_total++; if (rd_q[i] !== d[i]) $display("FAIL bp_byte%0d: got %h want %h", i, rd_q[i], d[i]); else n_pass++;
        end
    endtask

    task automatic test_full_rate();
        bit ok;
        logic [7:0] d [$];
        for (int i = 0; i < 16; i++) d.push_back(8'(8'h30 + i));
        issue_cmd(1'b1, 10'h300, 10'd15);
        drive_write(d, 0);
        wait_done(10, ok);
        rd_q.delete(); rdata_ready = 1'b1;
        issue_cmd(1'b0, 10'h300, 10'd15);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_total++; if (rdata_valid !== 1'b0) $display("FAIL fr_latency%0d: rdata_valid=%b want 0", c, rdata_valid); else n_pass++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_total++; if (rdata_valid !== 1'b1 || rdata !== d[i])
                $display("FAIL fr_beat%0d: got v=%b d=%h want v=1 d=%h", i, rdata_valid, rdata, d[i]); else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_total++; if (rdata_valid !== 1'b0 || done !== 1'b1)
            $display("FAIL fr_end: got v=%b done=%b want v=0 done=1", rdata_valid, done); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_stall();
        bit ok;
        wr_addr_q.delete(); wr_data_q.delete();
        issue_cmd(1'b1, 10'h050, 10'd3);
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1; wdata = 8'(8'h5A + i);
            @(negedge clk);
            n_total++; if (cmd_ready !== 1'b0 || ram_wr !== 1'b1)
                $display("FAIL ws_beat%0d: cmd_ready=%b ram_wr=%b want 0/1", i, cmd_ready, ram_wr); else n_pass++;
            @(posedge clk); #1;
            wdata_valid = 1'b0;
            if (i < 3) begin
                repeat (2) begin
                    @(negedge clk);
                    n_total++; if (cmd_ready !== 1'b0 || ram_wr !== 1'b0)
                        $display("FAIL ws_gap%0d: cmd_ready=%b ram_wr=%b want 0/0", i, cmd_ready, ram_wr); else n_pass++;
                    @(posedge clk); #1;
                end
            end
        end
        wait_done(10, ok);
        n_total++; if (!ok) $display("FAIL ws_done: no done pulse"); else n_pass++;
        n_total++; if (wr_addr_q.size() != 4) $display("FAIL ws_count: got %0d want 4", wr_addr_q.size()); else n_pass++;
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            n_total++; if (wr_addr_q[i] !== 10'(10'h050 + i) || wr_data_q[i] !== 8'(8'h5A + i))
                $display("FAIL ws_wr%0d: got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], 8'(8'h5A + i), 10'(10'h050 + i)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        rd_q.delete(); rdata_ready = 1'b1;
        issue_cmd(1'b0, 10'h300, 10'd9);
        for (int i = 0; i < 40 && rd_q.size() < 3; i++) begin @(posedge clk); #1; end
        n_total++; if (rd_q.size() != 3) $display("FAIL rmr_progress: got %0d bytes want 3", rd_q.size()); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 8'h00 ||
                       done !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 10'h000 || ram_din !== 8'h00)
            $display("FAIL rmr_outputs: cr=%b wr=%b rv=%b rd=%h dn=%b rw=%b ra=%h rdin=%h want 1 0 0 00 0 0 000 00",
                     cmd_ready, wdata_ready, rdata_valid, rdata, done, ram_wr, ram_addr, ram_din); else n_pass++;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rmr_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        @(posedge clk); #1;
        rd_q.delete();
        issue_cmd(1'b0, 10'h0FF, 10'd0);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL rmr_done: no done pulse"); else n_pass++;
        n_total++; if (rd_q.size() != 1) $display("FAIL rmr_count: got %0d want 1", rd_q.size()); else n_pass++;
        if (rd_q.size() > 0) begin
            n_total++; if (rd_q[0] !== 8'hEC) $display("FAIL rmr_byte: got %h want ec", rd_q[0]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_wrap();
        test_backpressure();
        test_full_rate();
        test_write_stall();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
